lgc_netlist_ver: RTL and testbench
==================================

// Module: lgc_netlist_ver
// PURPOSE
//  Control + datapath of the 16-bit SAYAC processor, register file excluded (external TRF).
//  Multicycle: fetches over the shared memory bus, decodes, executes, loads/stores.
//  Drives TRF read/write addresses and write data; takes both TRF read ports back in.
//  Top-level logic netlist, used for scan insertion and fault-list generation.
// PARAMETERS
//  none (16-bit data/address, 16 registers, fixed)
// PORTS
//  clk         in   1   single clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  readyMEM    in   1   memory completes current read/write this cycle
//  dataBusIn   in   16  memory read data (instruction or load data)
//  p1TRF       in   16  TRF read port 1 = R[outMuxrs1] (combinational)
//  p2TRF       in   16  TRF read port 2 = R[outMuxrs2] (combinational)
//  readMM      out  1   memory read request
//  writeMM     out  1   memory write request
//  dataBusOut  out  16  store data
//  addrBus     out  16  memory address
//  outMuxrs1   out  4   TRF read address 1
//  outMuxrs2   out  4   TRF read address 2
//  outMuxrd    out  4   TRF write address
//  inDataTRF   out  16  TRF write data
//  writeTRF    out  1   TRF write enable, sampled by TRF at clk edge
//  readInst    out  1   current read is an instruction fetch
// BEHAVIOUR
//  Instr: op=IR[15:12]. R-type: rs2=IR[11:8], rs1=IR[7:4], rd=IR[3:0]. I-type: imm8=IR[11:4], rd=IR[3:0].
//  sx = sign-extended imm8. outMuxrd=rd always.
//  outMuxrs1=rs1, outMuxrs2=rs2; override: MHI/ADI/BRZ rs1:=rd; STR rs2:=rd.
//  Ops: 0 NOP | 1 ANR rd=rs1&rs2 | 2 ADR rd=rs1+rs2 | 3 SUR rd=rs1-rs2 | 4 NTR rd=~rs1
//   5 SLR rd=rs1<<rs2[3:0] | 6 MSI rd=sx | 7 MHI rd={imm8,R[rd][7:0]} | 8 ADI rd=R[rd]+sx
//   9 LDR rd=M[rs1] | A STR M[rs1]=R[rd] | B JMR rd=PC, PC=rs1 | C JMI rd=PC, PC=PC+sx
//   D BRZ if R[rd]==0 PC=PC+sx (no write) | E,F = NOP. Arithmetic mod 2^16, no flags.
//  PC in JMR/JMI/BRZ = already-incremented PC (instr address+1).
//  FSM: IDLE, FETCH, EXEC, MEM.
//   IDLE: all outputs 0; -> FETCH next cycle.
//   FETCH: readMM=1, readInst=1, addrBus=PC. readyMEM=1: IR<=dataBusIn, PC<=PC+1, -> EXEC; else hold.
//   EXEC (1 cycle): ALU/imm/jump ops: writeTRF=1, inDataTRF=result, PC update, -> FETCH.
//    NOP/BRZ: writeTRF=0. LDR/STR -> MEM.
//   MEM: addrBus=p1TRF. LDR: readMM=1; on readyMEM writeTRF=1, inDataTRF=dataBusIn, -> FETCH.
//    STR: writeMM=1, dataBusOut=p2TRF; on readyMEM -> FETCH. readyMEM=0: hold state, outputs stable.
//  Non-active outputs are 0 (addrBus, dataBusOut, inDataTRF = 0 when unused).
//  Reset (any state, incl. mid-access): next cycle state=IDLE, PC=0, IR=0, all outputs 0.
//  readMM and writeMM are never both 1; writeTRF is 1 for at most one cycle per instruction.
//  Latency: ALU op 2 cycles, LDR/STR 3 cycles, with zero-wait memory.
// STRUCTURE
//  Package sayac_pkg: opcode localparams (OP_NOP..OP_BRZ), state enum, field-slice widths.
//  Sub-module sayac_alu: combinational, (op, a, b, imm8, pc) -> result, pc_next, branch_taken.
//  Top: PC, IR, FSM, output muxing.
// TESTING
//  Reset then zero-wait memory: first fetch addrBus=0000, readMM=readInst=1 on the cycle after IDLE.
//  MSI R1,0x05 (6051) then ADI R1,-1 (8FF1): writeTRF with inDataTRF=0005, then 0004, outMuxrd=1.
//  LDR R2,[R3] (9032), p1TRF=0x0100, dataBusIn=BEEF after 2 wait cycles: addrBus=0100 held,
//   then writeTRF=1, inDataTRF=BEEF, outMuxrd=2.
//  STR [R4],R5 (A045), p1TRF=0x0200, p2TRF=1234: writeMM=1, addrBus=0200, dataBusOut=1234.
//  JMI R6,+3 (C036) at addr 0010: inDataTRF=0011; next fetch addrBus=0014.
//  BRZ with p1TRF=0 branches, with p1TRF=1 does not; rst asserted during MEM wait -> IDLE, outputs 0.

Source files
------------

// File: rtl/sayac_pkg.sv
// Shared definitions for the SAYAC control/datapath netlist: opcodes,
// controller states, instruction field widths and small decode helpers.
package sayac_pkg;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 4;
    localparam int REG_W  = 4;
    localparam int IMM_W  = 8;

    localparam logic [OPC_W-1:0] OP_NOP = 4'h0;
    localparam logic [OPC_W-1:0] OP_ANR = 4'h1;
    localparam logic [OPC_W-1:0] OP_ADR = 4'h2;
    localparam logic [OPC_W-1:0] OP_SUR = 4'h3;
    localparam logic [OPC_W-1:0] OP_NTR = 4'h4;
    localparam logic [OPC_W-1:0] OP_SLR = 4'h5;
    localparam logic [OPC_W-1:0] OP_MSI = 4'h6;
    localparam logic [OPC_W-1:0] OP_MHI = 4'h7;
    localparam logic [OPC_W-1:0] OP_ADI = 4'h8;
    localparam logic [OPC_W-1:0] OP_LDR = 4'h9;
    localparam logic [OPC_W-1:0] OP_STR = 4'hA;
    localparam logic [OPC_W-1:0] OP_JMR = 4'hB;
    localparam logic [OPC_W-1:0] OP_JMI = 4'hC;
    localparam logic [OPC_W-1:0] OP_BRZ = 4'hD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_MEM   = 2'd3
    } state_t;

    // Sign-extend the 8-bit immediate to the datapath width.
    function automatic logic [DATA_W-1:0] sign_ext8(input logic [IMM_W-1:0] imm);
        sign_ext8 = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

    // Opcodes that deliver a value to rd.
    function automatic logic writes_rd(input logic [OPC_W-1:0] op);
        case (op)
            OP_ANR, OP_ADR, OP_SUR, OP_NTR, OP_SLR, OP_MSI,
            OP_MHI, OP_ADI, OP_LDR, OP_JMR, OP_JMI: writes_rd = 1'b1;
            default:                                 writes_rd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/sayac_alu.sv
// Combinational execute unit: computes the rd result and the next PC for the
// single-cycle (non-memory) instructions. 'a' is read port 1, 'b' read port 2,
// 'pc' is the already-incremented program counter.
module sayac_alu
    import sayac_pkg::*;
(
    input  logic [OPC_W-1:0]  op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [IMM_W-1:0]  imm8,
    input  logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] pc_next,
    output logic              branch_taken
);

    logic [DATA_W-1:0] sx;
    assign sx = sign_ext8(imm8);

    // Per-opcode result and control-flow evaluation
    always_comb begin
        result       = 16'h0000;
        pc_next      = pc;
        branch_taken = 1'b0;
        case (op)
            OP_ANR: result = a & b;
            OP_ADR: result = a + b;
            OP_SUR: result = a - b;
            OP_NTR: result = ~a;
            OP_SLR: result = a << b[3:0];
            OP_MSI: result = sx;
            OP_MHI: result = {imm8, a[7:0]};
            OP_ADI: result = a + sx;
            OP_JMR: begin
                result       = pc;
                pc_next      = a;
                branch_taken = 1'b1;
            end
            OP_JMI: begin
                result       = pc;
                pc_next      = pc + sx;
                branch_taken = 1'b1;
            end
            OP_BRZ: begin
                if (a == 16'h0000) begin
                    pc_next      = pc + sx;
                    branch_taken = 1'b1;
                end else begin
                    pc_next      = pc;
                    branch_taken = 1'b0;
                end
            end
            default: begin
                result       = 16'h0000;
                pc_next      = pc;
                branch_taken = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/lgc_netlist_ver.sv
// SAYAC processor control and datapath without the register file. A four-state
// multicycle controller fetches over the shared memory bus, executes in one
// cycle, and uses an extra state for loads and stores. TRF reads come back
// combinationally on p1TRF/p2TRF.
module lgc_netlist_ver
    import sayac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              readyMEM,
    input  logic [DATA_W-1:0] dataBusIn,
    input  logic [DATA_W-1:0] p1TRF,
    input  logic [DATA_W-1:0] p2TRF,
    output logic              readMM,
    output logic              writeMM,
    output logic [DATA_W-1:0] dataBusOut,
    output logic [DATA_W-1:0] addrBus,
    output logic [REG_W-1:0]  outMuxrs1,
    output logic [REG_W-1:0]  outMuxrs2,
    output logic [REG_W-1:0]  outMuxrd,
    output logic [DATA_W-1:0] inDataTRF,
    output logic              writeTRF,
    output logic              readInst
);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] ir;
    logic              load_ir;
    logic              load_pc;

    logic [OPC_W-1:0]  op;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rd;
    logic [IMM_W-1:0]  imm8;

    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] alu_pc_next;
    logic              alu_taken;

    assign op   = ir[15:12];
    assign rs2  = ir[11:8];
    assign rs1  = ir[7:4];
    assign rd   = ir[3:0];
    assign imm8 = ir[11:4];

    sayac_alu u_alu (
        .op           (op),
        .a            (p1TRF),
        .b            (p2TRF),
        .imm8         (imm8),
        .pc           (pc),
        .result       (alu_result),
        .pc_next      (alu_pc_next),
        .branch_taken (alu_taken)
    );

    // TRF addressing: instructions operating on R[rd] read it through a port
    always_comb begin
        outMuxrd = rd;
        if ((op == OP_MHI) || (op == OP_ADI) || (op == OP_BRZ)) begin
            outMuxrs1 = rd;
        end else begin
            outMuxrs1 = rs1;
        end
        if (op == OP_STR) begin
            outMuxrs2 = rd;
        end else begin
            outMuxrs2 = rs2;
        end
    end

    // Controller state, program counter and instruction register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= 16'h0000;
            ir    <= 16'h0000;
        end else begin
            state <= state_next;
            if (load_ir) begin
                ir <= dataBusIn;
                pc <= pc + 16'd1;
            end else if (load_pc) begin
                pc <= alu_pc_next;
            end
        end
    end

    // Next-state decode and bus/TRF output drive; unused outputs stay zero
    always_comb begin
        state_next = state;
        readMM     = 1'b0;
        writeMM    = 1'b0;
        readInst   = 1'b0;
        addrBus    = 16'h0000;
        dataBusOut = 16'h0000;
        inDataTRF  = 16'h0000;
        writeTRF   = 1'b0;
        load_ir    = 1'b0;
        load_pc    = 1'b0;
        case (state)
            ST_IDLE: begin
                state_next = ST_FETCH;
            end
            ST_FETCH: begin
                readMM   = 1'b1;
                readInst = 1'b1;
                addrBus  = pc;
                if (readyMEM) begin
                    load_ir    = 1'b1;
                    state_next = ST_EXEC;
                end else begin
                    state_next = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if ((op == OP_LDR) || (op == OP_STR)) begin
                    state_next = ST_MEM;
                end else begin
                    state_next = ST_FETCH;
                    writeTRF   = writes_rd(op);
                    inDataTRF  = writes_rd(op) ? alu_result : 16'h0000;
                    load_pc    = alu_taken;
                end
            end
            ST_MEM: begin
                addrBus = p1TRF;
                if (op == OP_LDR) begin
                    readMM = 1'b1;
                    if (readyMEM) begin
                        writeTRF   = 1'b1;
                        inDataTRF  = dataBusIn;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_MEM;
                    end
                end else begin
                    writeMM    = 1'b1;
                    dataBusOut = p2TRF;
                    if (readyMEM) begin
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_MEM;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lgc_netlist_ver.sv
// Bench for lgc_netlist_ver. The bench plays register file and memory; an
// instruction-level model of SAYAC predicts fetch addresses, TRF writes and
// stores, which a monitor compares against what the DUT presents.
module tb_lgc_netlist_ver;

    logic        clk = 1'b0;
    logic        rst;
    logic        readyMEM;
    logic [15:0] dataBusIn;
    logic [15:0] p1TRF;
    logic [15:0] p2TRF;
    logic        readMM;
    logic        writeMM;
    logic [15:0] dataBusOut;
    logic [15:0] addrBus;
    logic [3:0]  outMuxrs1;
    logic [3:0]  outMuxrs2;
    logic [3:0]  outMuxrd;
    logic [15:0] inDataTRF;
    logic        writeTRF;
    logic        readInst;

    lgc_netlist_ver dut (
        .clk        (clk),
        .rst        (rst),
        .readyMEM   (readyMEM),
        .dataBusIn  (dataBusIn),
        .p1TRF      (p1TRF),
        .p2TRF      (p2TRF),
        .readMM     (readMM),
        .writeMM    (writeMM),
        .dataBusOut (dataBusOut),
        .addrBus    (addrBus),
        .outMuxrs1  (outMuxrs1),
        .outMuxrs2  (outMuxrs2),
        .outMuxrd   (outMuxrd),
        .inDataTRF  (inDataTRF),
        .writeTRF   (writeTRF),
        .readInst   (readInst)
    );

    always #5 clk = ~clk;

    // Environment state seen by the DUT and the model's private copy
    logic [15:0] rf      [16];
    logic [15:0] mem     [4096];
    logic [15:0] ref_rf  [16];
    logic [15:0] ref_mem [4096];

    assign p1TRF     = rf[outMuxrs1];
    assign p2TRF     = rf[outMuxrs2];
    assign dataBusIn = mem[addrBus[11:0]];

    // Scoreboard queues
    logic [15:0] fetch_q [$];
    logic [19:0] trf_q   [$];
    logic [31:0] st_q    [$];

    int   n_checks = 0;
    int   n_errors = 0;
    logic chk_en   = 1'b0;
    int   exp_mode = 0;
    logic force_wait = 1'b0;

    // ---------------- reference model ----------------
    task automatic model_wr(input logic [3:0] r, input logic [15:0] v);
        trf_q.push_back({r, v});
        ref_rf[r] = v;
    endtask

    task automatic run_iss(input int n);
        logic [15:0] pc, ir, a, b, d, sx;
        logic [3:0]  op, rd, rs1, rs2;
        pc = 16'h0000;
        for (int k = 0; k < n; k++) begin
            fetch_q.push_back(pc);
            ir  = ref_mem[pc[11:0]];
            pc  = pc + 16'd1;
            op  = ir[15:12];
            rs2 = ir[11:8];
            rs1 = ir[7:4];
            rd  = ir[3:0];
            sx  = {{8{ir[11]}}, ir[11:4]};
            a   = ref_rf[rs1];
            b   = ref_rf[rs2];
            d   = ref_rf[rd];
            case (op)
                4'h1: model_wr(rd, a & b);
                4'h2: model_wr(rd, a + b);
                4'h3: model_wr(rd, a - b);
                4'h4: model_wr(rd, ~a);
                4'h5: model_wr(rd, a << b[3:0]);
                4'h6: model_wr(rd, sx);
                4'h7: model_wr(rd, {ir[11:4], d[7:0]});
                4'h8: model_wr(rd, d + sx);
                4'h9: model_wr(rd, ref_mem[a[11:0]]);
                4'hA: begin
                    st_q.push_back({a, d});
                    ref_mem[a[11:0]] = d;
                end
                4'hB: begin
                    model_wr(rd, pc);
                    pc = a;
                end
                4'hC: begin
                    model_wr(rd, pc);
                    pc = pc + sx;
                end
                4'hD: if (d == 16'h0000) pc = pc + sx;
                default: ;
            endcase
        end
        fetch_q.push_back(pc);
    endtask

    // ---------------- monitor ----------------
    logic [15:0] exp_addr;
    logic [19:0] exp_trf;
    logic [31:0] exp_st;
    logic        hold_prev = 1'b0;
    logic [34:0] hold_val;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("rw_exclusive", {63'd0, readMM & writeMM}, 64'd0);
            if (readMM && readInst && readyMEM) begin
                if (fetch_q.size() == 0) begin
                    check("fetch_unexpected", {48'd0, addrBus}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_addr = fetch_q.pop_front();
                    check("fetch_addr", {48'd0, addrBus}, {48'd0, exp_addr});
                end
            end
            if (writeTRF) begin
                if (trf_q.size() == 0) begin
                    check("trf_unexpected", {44'd0, outMuxrd, inDataTRF}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_trf = trf_q.pop_front();
                    check("trf_write", {44'd0, outMuxrd, inDataTRF}, {44'd0, exp_trf});
                end
            end
            if (writeMM && readyMEM) begin
                if (st_q.size() == 0) begin
                    check("store_unexpected", {32'd0, addrBus, dataBusOut}, 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    exp_st = st_q.pop_front();
                    check("store", {32'd0, addrBus, dataBusOut}, {32'd0, exp_st});
                end
            end
            if (hold_prev) begin
                check("wait_hold", {29'd0, readMM, writeMM, readInst, addrBus, dataBusOut},
                      {29'd0, hold_val});
            end
            hold_prev = (readMM || writeMM) && !readyMEM;
            hold_val  = {readMM, writeMM, readInst, addrBus, dataBusOut};
        end else begin
            hold_prev = 1'b0;
        end
        case (exp_mode)
            1: check("idle_zero",
                     {readMM, writeMM, readInst, writeTRF, outMuxrs1, outMuxrs2, outMuxrd,
                      addrBus, dataBusOut, inDataTRF}, 64'd0);
            2: check("first_fetch", {44'd0, readMM, readInst, writeMM, writeTRF, addrBus},
                     {44'd0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000});
            3: check("queues_drained", 64'(fetch_q.size() + trf_q.size() + st_q.size()), 64'd0);
            4: check("timeout", 64'd1, 64'd0);
            5: check("mem_wait", {44'd0, readMM, readInst, writeMM, writeTRF, addrBus},
                     {44'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0100});
            default: ;
        endcase
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        logic        w_trf, w_mm;
        logic [3:0]  w_a;
        logic [15:0] w_d, m_a, m_d;
        @(negedge clk);
        w_trf = writeTRF;
        w_a   = outMuxrd;
        w_d   = inDataTRF;
        w_mm  = writeMM && readyMEM;
        m_a   = addrBus;
        m_d   = dataBusOut;
        @(posedge clk);
        #1;
        if (w_trf === 1'b1) rf[w_a] = w_d;
        if (w_mm === 1'b1) mem[m_a[11:0]] = m_d;
        if (force_wait) readyMEM = !(writeMM || (readMM && !readInst));
        else            readyMEM = ($urandom_range(0, 2) != 0);
    endtask

    task automatic run_phase(input int n);
        int cnt;
        fetch_q.delete();
        trf_q.delete();
        st_q.delete();
        for (int i = 0; i < 4096; i++) ref_mem[i] = mem[i];
        for (int i = 0; i < 16; i++) ref_rf[i] = rf[i];
        run_iss(n);
        rst    = 1'b1;
        chk_en = 1'b0;
        repeat (2) cyc();
        exp_mode = 1;
        cyc();
        rst      = 1'b0;
        chk_en   = 1'b1;
        cyc();
        exp_mode = 2;
        cyc();
        exp_mode = 0;
        cnt = 0;
        while (fetch_q.size() != 0 && cnt < 20000) begin
            cyc();
            cnt++;
        end
        chk_en   = 1'b0;
        exp_mode = (fetch_q.size() != 0) ? 4 : 3;
        rst      = 1'b1;
        cyc();
        exp_mode = 0;
    endtask

    initial begin
        int cnt;
        rst      = 1'b1;
        readyMEM = 1'b0;

        // Directed program covering the documented scenarios
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 16; i++) rf[i] = 16'h0000;
        mem[12'h000] = 16'h6051;   // MSI R1,0x05
        mem[12'h001] = 16'h8FF1;   // ADI R1,-1
        mem[12'h002] = 16'h9032;   // LDR R2,[R3]
        mem[12'h003] = 16'hA045;   // STR [R4],R5
        mem[12'h004] = 16'hC0B6;   // JMI R6,+11 -> 0x0010
        mem[12'h010] = 16'hC036;   // JMI R6,+3  -> 0x0014
        mem[12'h014] = 16'hD017;   // BRZ R7 (=0) +1 -> 0x0016
        mem[12'h016] = 16'hD018;   // BRZ R8 (=1) not taken
        mem[12'h017] = 16'h2121;   // ADR R1 = R2 + R1
        mem[12'h100] = 16'hBEEF;
        rf[3] = 16'h0100;
        rf[4] = 16'h0200;
        rf[5] = 16'h1234;
        rf[8] = 16'h0001;
        run_phase(9);

        // Random programs over random register/memory contents
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
            for (int i = 0; i < 16; i++) rf[i] = 16'($urandom);
            run_phase(300);
        end

        // Reset while a load waits on memory
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[12'h000] = 16'h9032;
        rf[3]      = 16'h0100;
        force_wait = 1'b1;
        rst        = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();
        cnt = 0;
        while (!(readMM && !readInst) && cnt < 50) begin
            cyc();
            cnt++;
        end
        if (cnt >= 50) begin
            exp_mode = 4;
            cyc();
        end
        exp_mode = 5;
        cyc();
        rst = 1'b1;
        cyc();
        exp_mode = 1;
        cyc();
        rst = 1'b0;
        cyc();
        exp_mode = 2;
        cyc();
        exp_mode = 0;
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
